reg_dump_uart_tx: RTL and testbench
===================================

Name: reg_dump_uart_tx

Overview:
- Debug readout block for the CPU's exported register outputs (reg0..reg25).
- On a start pulse it snapshots all 26 registers and serialises them over a UART 8N1 transmit line as a framed packet: sync byte, register bytes, checksum byte.
- It sits beside the CPU at top level and is the read-out end of the register export interface.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range is 2 or more.
- NUM_REGS, 26, number of 32-bit registers in the frame.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a dump; sampled every cycle.
- regs_flat  in  32*NUM_REGS  reg0 in bits [31:0], reg1 in bits [63:32], and so on up to reg25.
- tx  out  1  UART serial output; idle level is 1.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset (asynchronous, active-low):
  - tx=1, busy=0, done=0.
  - State goes to IDLE; bit counter, byte counter, baud counter and checksum clear.
  - Reset asserted mid-frame aborts the frame immediately: tx returns to 1 and no done pulse is produced.
- Frame layout: SYNC_BYTE, then 4*NUM_REGS data bytes, then a checksum byte. Default frame is 106 bytes.
- Data byte order:
  - Registers in order reg0 to reg(NUM_REGS-1).
  - Each register is sent MSB byte first: [31:24], [23:16], [15:8], [7:0].
- Checksum: XOR of all data bytes. SYNC_BYTE is excluded.
- Byte format: 8N1. Start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles.
- Byte spacing: bytes are sent back-to-back with no idle gap between a stop bit and the next start bit.
- State machine:
  - IDLE: start=1 captures regs_flat into an internal snapshot, clears the checksum, loads SYNC_BYTE, and goes to START. busy and tx change on the next edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[bit_idx] for CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
    - If more bytes remain, load the next byte. For a data byte, fold it into the checksum at load time. Go to START.
    - If the checksum byte has just been sent, go to IDLE, pulse done, and drop busy on the same edge.
- Latency:
  - start is sampled high at edge k; busy=1 and tx=0 from edge k+1.
  - Total frame time is 106*10*CLKS_PER_BIT cycles from edge k+1 to the done pulse.
- Snapshot: changes on regs_flat after the capture edge have no effect on the frame in flight.
- start while busy=1 is ignored. It is not queued.
- start held high continuously causes a new frame to begin on the edge after done, because IDLE is re-entered and samples start.
- done and busy are never high together. done is high for exactly one cycle per completed frame.
- Counters:
  - The baud counter counts 0 to CLKS_PER_BIT-1 and wraps.
  - The byte index is wide enough to hold 4*NUM_REGS+1, and its wrap is never reached within a frame.
- tx is driven from a register, so it is glitch-free.

Test Plan:
- Reset check: assert rst_n=0 -> tx=1, busy=0, done=0. Release reset with start=0 for 100 cycles -> tx stays 1 throughout.
- All-zero frame (CLKS_PER_BIT=4, all regs 0):
  - Pulse start -> decoded bytes are A5, then 104 bytes of 00, then checksum 00.
  - done pulses exactly 4240 cycles after busy rises.
- Byte ordering and checksum (reg0=32'h12345678, others 0):
  - Decoded bytes 1..4 are 12 34 56 78.
  - Checksum is 08.
  - Changing regs_flat 10 cycles after start does not alter the decoded frame.
- Full pattern (reg n = 32'h01010101*n, n=0..25):
  - Every byte of register n equals n.
  - Checksum is 00, since each value appears 4 times.
  - Each bit is exactly 4 cycles wide.
- start pulse while busy -> ignored: exactly one frame and one done pulse. start held high -> second frame's start bit begins on the cycle after done.
- Reset mid-frame: drop rst_n during the DATA bits of byte 50 -> tx=1 and busy=0 immediately, no done pulse. The next start produces a complete, correct frame.

Source files
------------

// File: rtl/reg_dump_uart_tx.sv
// Debug readout: snapshots NUM_REGS 32-bit registers on start and sends them over a UART 8N1
// line as a frame of SYNC_BYTE, register bytes (MSB first, reg0 first), and an XOR checksum.
module reg_dump_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_REGS     = 26,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [32*NUM_REGS-1:0]   regs_flat,
    output logic                     tx,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned NumData = 4 * NUM_REGS;
    localparam int unsigned LastIdx = NumData + 1;
    localparam int unsigned ByteW   = $clog2(LastIdx + 1);
    localparam int unsigned BaudW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned SnapW   = 32 * NUM_REGS;
    localparam int unsigned OffW    = $clog2(SnapW);

    localparam logic [BaudW-1:0] BaudMax  = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [ByteW-1:0] NumDataB = ByteW'(NumData);
    localparam logic [ByteW-1:0] LastIdxB = ByteW'(LastIdx);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    // Index of the byte currently on the line: 0 is sync, 1..NumData data, LastIdx checksum.
    logic [ByteW-1:0]   byte_idx_q, byte_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         csum_q, csum_d;
    logic [SnapW-1:0]   snap_q, snap_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               baud_wrap;
    logic [ByteW-1:0]   data_sel;
    logic [OffW-1:0]    byte_off;
    logic [7:0]         data_byte;

    assign baud_wrap = (baud_q == BaudMax);

    // The next data byte to load has index byte_idx_q; within a register the byte order is
    // reversed, so flipping the low two index bits gives the little-endian byte offset.
    always_comb begin
        data_sel  = (byte_idx_q < NumDataB) ? byte_idx_q : '0;
        byte_off  = OffW'({data_sel ^ ByteW'(3), 3'b000});
        data_byte = snap_q[byte_off +: 8];
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        snap_d     = snap_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StStart;
                    snap_d     = regs_flat;
                    csum_d     = '0;
                    shift_d    = SYNC_BYTE;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    baud_d     = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            StStart: begin
                if (baud_wrap) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            StData: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            StStop: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (byte_idx_q == LastIdxB) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        tx_d    = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = StStart;
                        tx_d       = 1'b0;
                        // Each data byte is folded in as it is loaded, so once the last data
                        // byte has gone out csum_q already holds the final checksum.
                        if (byte_idx_q < NumDataB) begin
                            shift_d = data_byte;
                            csum_d  = csum_q ^ data_byte;
                        end else begin
                            shift_d = csum_q;
                        end
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            snap_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            snap_q     <= snap_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Bench for reg_dump_uart_tx: builds the expected byte stream from the register values and
// checks the serial line cycle by cycle, plus busy/done framing, start handling and reset.
module tb_reg_dump_uart_tx;

    localparam int C        = 4;
    localparam int N        = 26;
    localparam int NB       = 4 * N + 2;
    localparam int FrameCyc = NB * 10 * C;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [32*N-1:0]  regs_flat = '0;
    logic             tx;
    logic             busy;
    logic             done;

    reg_dump_uart_tx #(
        .CLKS_PER_BIT (C),
        .NUM_REGS     (N),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .regs_flat (regs_flat),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int          asserts = 0;
    int          fails = 0;
    logic [31:0] model_regs [N];
    logic [7:0]  exp_bytes [NB];

    // Frame model: sync, every register MSB byte first, then XOR of the data bytes.
    task automatic build_expected();
        logic [7:0] csum;
        int         k;
        csum = 8'h00;
        k = 1;
        exp_bytes[0] = 8'hA5;
        for (int r = 0; r < N; r++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_bytes[k] = model_regs[r][8*b +: 8];
                csum = csum ^ exp_bytes[k];
                k++;
            end
        end
        exp_bytes[NB-1] = csum;
        for (int r = 0; r < N; r++) regs_flat[32*r +: 32] = model_regs[r];
    endtask

    task automatic capture_frame(input string tag, input bit do_pulse, input bit hold,
                                 input int change_at, input int extra_start_at);
        int         bad_bits;
        int         first_bad;
        int         bad_ctrl;
        int         j;
        int         byt;
        int         pos;
        logic       exp_bit;
        logic [7:0] dec;
        bad_bits  = 0;
        first_bad = -1;
        bad_ctrl  = 0;
        dec       = '0;
        if (do_pulse) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int i = 0; i < FrameCyc; i++) begin
            if (i > 0) @(negedge clk);
            j   = i / C;
            byt = j / 10;
            pos = j % 10;
            if (pos == 0) exp_bit = 1'b0;
            else if (pos == 9) exp_bit = 1'b1;
            else exp_bit = exp_bytes[byt][pos-1];
            if (tx !== exp_bit) begin
                bad_bits++;
                if (first_bad < 0) first_bad = i;
            end
            if (busy !== 1'b1 || done !== 1'b0) bad_ctrl++;
            if (pos >= 1 && pos <= 8 && (i % C) == C / 2) dec[pos-1] = tx;
            if (pos == 9 && (i % C) == C - 1) begin
                asserts++;
                if (dec !== exp_bytes[byt]) begin
                    fails++;
                    $display("FAIL %s byte %0d: got %02h expected %02h",
                             tag, byt, dec, exp_bytes[byt]);
                end
            end
            if (i == change_at) begin
                for (int r = 0; r < N; r++) regs_flat[32*r +: 32] = $urandom;
            end
            if (i == extra_start_at) start = 1'b1;
            if (i == extra_start_at + 1) start = 1'b0;
        end
        @(negedge clk);
        asserts++;
        if (bad_bits != 0) begin
            fails++;
            $display("FAIL %s bit_timing: %0d wrong tx cycles (first at %0d), expected 0",
                     tag, bad_bits, first_bad);
        end
        asserts++;
        if (bad_ctrl != 0) begin
            fails++;
            $display("FAIL %s busy_done_in_frame: %0d bad cycles, expected 0", tag, bad_ctrl);
        end
        asserts++;
        if (done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            fails++;
            $display("FAIL %s frame_end at cycle %0d: done=%b busy=%b tx=%b expected 1 0 1",
                     tag, FrameCyc, done, busy, tx);
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        asserts++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s idle: %0d non-idle cycles, expected 0", tag, bad);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        asserts++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: tx=%b busy=%b done=%b expected 1 0 0", tx, busy, done);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_idle("after_reset", 100);
    endtask

    task automatic test_all_zero();
        for (int r = 0; r < N; r++) model_regs[r] = '0;
        build_expected();
        capture_frame("all_zero", 1'b1, 1'b0, -1, -10);
    endtask

    task automatic test_byte_order();
        for (int r = 0; r < N; r++) model_regs[r] = '0;
        model_regs[0] = 32'h12345678;
        build_expected();
        capture_frame("byte_order", 1'b1, 1'b0, 10, -10);
    endtask

    task automatic test_full_pattern();
        for (int r = 0; r < N; r++) model_regs[r] = 32'h01010101 * r;
        build_expected();
        capture_frame("full_pattern", 1'b1, 1'b0, -1, -10);
    endtask

    task automatic test_random(input string tag);
        for (int r = 0; r < N; r++) model_regs[r] = $urandom;
        build_expected();
        capture_frame(tag, 1'b1, 1'b0, int'($urandom_range(0, FrameCyc - 1)), -10);
    endtask

    task automatic test_ignore_start();
        for (int r = 0; r < N; r++) model_regs[r] = $urandom;
        build_expected();
        capture_frame("ignore_start", 1'b1, 1'b0, -1, int'($urandom_range(20, 3000)));
        check_idle("ignore_start", 40);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < N; r++) model_regs[r] = $urandom;
        build_expected();
        capture_frame("held_first", 1'b1, 1'b1, -1, -10);
        capture_frame("held_second", 1'b0, 1'b0, -1, -10);
        check_idle("held_after", 20);
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        bad = 0;
        for (int r = 0; r < N; r++) model_regs[r] = '0;
        build_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50 * 10 * C + 4 * C + 1) @(negedge clk);
        asserts++;
        if (busy !== 1'b1 || tx !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_pre: busy=%b tx=%b expected 1 0", busy, tx);
        end
        rst_n = 1'b0;
        #1;
        asserts++;
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_abort: tx=%b busy=%b done=%b expected 1 0 0",
                     tx, busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        asserts++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mid_reset_no_done: %0d bad cycles, expected 0", bad);
        end
        test_random("after_mid_reset");
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_byte_order();
        test_full_pattern();
        test_random("random_a");
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
